// File: rtl/shift_rows_serial.sv
// Byte-serial AES ShiftRows / InvShiftRows engine with ping-pong block buffers.
// Bytes stream in column-major state order and leave in the same order, permuted.
module shift_rows_serial #(
  parameter bit INV = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready
);

  logic [7:0] r_buf [2][16];
  logic       r_wrSel;
  logic       r_rdSel;
  logic [3:0] r_wrCnt;
  logic [3:0] r_rdCnt;
  logic [1:0] r_full;

  logic       w_inFire;
  logic       w_outFire;
  logic [1:0] w_srcCol;
  logic [3:0] w_srcIdx;
  logic [1:0] w_fullNext;

  assign in_ready  = !r_full[r_wrSel];
  assign out_valid = r_full[r_rdSel];
  assign w_inFire  = in_valid && in_ready;
  assign w_outFire = out_valid && out_ready;

  // Output byte 4c+r reads input column c+r (or c-r for the inverse); the
  // 2-bit adder wraps the column index mod 4 for free.
  always_comb begin
    w_srcCol = INV ? (r_rdCnt[3:2] - r_rdCnt[1:0]) : (r_rdCnt[3:2] + r_rdCnt[1:0]);
    w_srcIdx = {w_srcCol, r_rdCnt[1:0]};
  end

  assign out_byte = r_buf[r_rdSel][w_srcIdx];

  // Fill and drain always target different buffers, so both updates may land together.
  always_comb begin
    w_fullNext = r_full;
    if (w_inFire && (r_wrCnt == 4'd15)) begin
      w_fullNext[r_wrSel] = 1'b1;
    end
    if (w_outFire && (r_rdCnt == 4'd15)) begin
      w_fullNext[r_rdSel] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r_buf[0][i] <= 8'h00;
        r_buf[1][i] <= 8'h00;
      end
    end else if (w_inFire) begin
      r_buf[r_wrSel][r_wrCnt] <= in_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrSel <= 1'b0;
      r_wrCnt <= 4'd0;
      r_rdSel <= 1'b0;
      r_rdCnt <= 4'd0;
      r_full  <= 2'b00;
    end else begin
      r_full <= w_fullNext;
      if (w_inFire) begin
        r_wrCnt <= r_wrCnt + 4'd1;
        if (r_wrCnt == 4'd15) begin
          r_wrSel <= !r_wrSel;
        end
      end
      if (w_outFire) begin
        r_rdCnt <= r_rdCnt + 4'd1;
        if (r_rdCnt == 4'd15) begin
          r_rdSel <= !r_rdSel;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_rows_serial.sv
// Bench for shift_rows_serial: forward and inverse instances share one input
// stream and are scored against a matrix-level ShiftRows model.
module tb_shift_rows_serial;

  logic       clk;
  logic       rst;
  logic [7:0] inByte;
  logic       inValid;
  logic       outReady;
  logic       fwdInReady;
  logic [7:0] fwdOutByte;
  logic       fwdOutValid;
  logic       invInReady;
  logic [7:0] invOutByte;
  logic       invOutValid;

  shift_rows_serial #(.INV(1'b0)) dutFwd (
    .clk(clk), .rst(rst),
    .in_byte(inByte), .in_valid(inValid), .in_ready(fwdInReady),
    .out_byte(fwdOutByte), .out_valid(fwdOutValid), .out_ready(outReady)
  );

  shift_rows_serial #(.INV(1'b1)) dutInv (
    .clk(clk), .rst(rst),
    .in_byte(inByte), .in_valid(inValid), .in_ready(invInReady),
    .out_byte(invOutByte), .out_valid(invOutValid), .out_ready(outReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] inQ[$];
  logic [7:0] acceptBlk[$];
  logic [7:0] fwdExp[$];
  logic [7:0] invExp[$];
  logic [7:0] fwdGot[$];
  logic [7:0] invGot[$];

  int compareCount = 0;
  int mismatchCount = 0;
  int cyc = 0;
  int acceptCount = 0;
  int lastBlockCyc = -1;
  int fwdOutCount = 0;
  int firstOutCyc = -1;
  int lastOutCyc = -1;
  bit randOut = 1'b0;
  bit randIn = 1'b0;

  // Row r of the 4x4 state rotates left by r (right by r for the inverse).
  function automatic logic [127:0] shiftModel(input logic [127:0] st, input bit inv);
    logic [7:0]   m [4][4];
    logic [127:0] res;
    int           sc;
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = st[127 - 8 * (4 * c + r) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        sc = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
        res[127 - 8 * (4 * c + r) -: 8] = m[r][sc];
      end
    return res;
  endfunction

  task automatic checkEq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    if (randOut) outReady = 1'($urandom_range(0, 1));
    if (!(inValid && !fwdInReady)) begin
      inValid = (inQ.size() > 0) && (!randIn || ($urandom_range(0, 3) != 0));
    end
    inByte = (inQ.size() > 0) ? inQ[0] : 8'h00;
  endtask

  // Sample at the falling edge, score every handshake, then step past the rising edge.
  task automatic checkOutput();
    logic [127:0] blkWord;
    logic [127:0] fwdWord;
    logic [127:0] invWord;
    logic [7:0]   expByte;
    @(negedge clk);
    if (inValid && fwdInReady) begin
      acceptBlk.push_back(inQ.pop_front());
      acceptCount++;
      if (acceptBlk.size() == 16) begin
        for (int k = 0; k < 16; k++) blkWord[127 - 8 * k -: 8] = acceptBlk[k];
        fwdWord = shiftModel(blkWord, 1'b0);
        invWord = shiftModel(blkWord, 1'b1);
        for (int k = 0; k < 16; k++) begin
          fwdExp.push_back(fwdWord[127 - 8 * k -: 8]);
          invExp.push_back(invWord[127 - 8 * k -: 8]);
        end
        acceptBlk.delete();
        lastBlockCyc = cyc;
      end
    end
    if (fwdOutValid && outReady) begin
      checkEq("fwdExpectedOutput", 128'(fwdExp.size() > 0), 128'(1));
      if (fwdExp.size() > 0) begin
        expByte = fwdExp.pop_front();
        checkEq("fwdByte", 128'(fwdOutByte), 128'(expByte));
      end
      fwdGot.push_back(fwdOutByte);
      fwdOutCount++;
      if (firstOutCyc < 0) firstOutCyc = cyc;
      lastOutCyc = cyc;
    end
    if (invOutValid && outReady) begin
      checkEq("invExpectedOutput", 128'(invExp.size() > 0), 128'(1));
      if (invExp.size() > 0) begin
        expByte = invExp.pop_front();
        checkEq("invByte", 128'(invOutByte), 128'(expByte));
      end
      invGot.push_back(invOutByte);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      applyStimulus();
      checkOutput();
    end
  endtask

  task automatic drainAll(input string tag, input int budget);
    while ((inQ.size() > 0 || fwdExp.size() > 0 || invExp.size() > 0) && budget > 0) begin
      runCycles(1);
      budget--;
    end
    checkEq(tag, 128'(inQ.size() + fwdExp.size() + invExp.size()), 128'(0));
  endtask

  task automatic clearModel();
    inQ.delete();
    acceptBlk.delete();
    fwdExp.delete();
    invExp.delete();
    inValid = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkEq({tag, "_fwdInReady"}, 128'(fwdInReady), 128'(1));
    checkEq({tag, "_fwdOutValid"}, 128'(fwdOutValid), 128'(0));
    checkEq({tag, "_fwdOutByte"}, 128'(fwdOutByte), 128'(0));
    checkEq({tag, "_invInReady"}, 128'(invInReady), 128'(1));
    checkEq({tag, "_invOutValid"}, 128'(invOutValid), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]   fwdSpec [16];
    logic [127:0] key;
    logic [127:0] word;
    int           startCyc;
    int           budget;

    fwdSpec = '{8'h00, 8'h05, 8'h0a, 8'h0f, 8'h04, 8'h09, 8'h0e, 8'h03,
                8'h08, 8'h0d, 8'h02, 8'h07, 8'h0c, 8'h01, 8'h06, 8'h0b};
    key = 128'hd1ed44fd1a0f3f2afa4ff27b7c332a69;

    rst = 1'b1; inValid = 1'b0; inByte = 8'h00; outReady = 1'b0;
    #3;
    checkResetOutputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Forward single block with latency check.
    $display("[TB] forward single block");
    outReady = 1'b1; fwdGot.delete(); firstOutCyc = -1;
    for (int i = 0; i < 16; i++) inQ.push_back(8'(i));
    drainAll("fwdDrain", 100);
    checkEq("fwdLatency", 128'(firstOutCyc - lastBlockCyc), 128'(1));
    word = '0;
    for (int k = 0; k < 16 && k < fwdGot.size(); k++) word[127 - 8 * k -: 8] = fwdGot[k];
    for (int k = 0; k < 16; k++) checkEq($sformatf("fwdSpec%0d", k), 128'(word[127 - 8 * k -: 8]), 128'(fwdSpec[k]));

    // Inverse of the documented forward result restores 00..0f.
    $display("[TB] inverse single block");
    invGot.delete();
    for (int i = 0; i < 16; i++) inQ.push_back(fwdSpec[i]);
    drainAll("invDrain", 100);
    word = '0;
    for (int k = 0; k < 16 && k < invGot.size(); k++) word[127 - 8 * k -: 8] = invGot[k];
    checkEq("invSpec", word, 128'h000102030405060708090a0b0c0d0e0f);

    // Round trip through both instances.
    $display("[TB] round trip");
    fwdGot.delete();
    for (int k = 0; k < 16; k++) inQ.push_back(key[127 - 8 * k -: 8]);
    drainAll("rtFwdDrain", 100);
    invGot.delete();
    for (int k = 0; k < 16 && k < fwdGot.size(); k++) inQ.push_back(fwdGot[k]);
    drainAll("rtInvDrain", 100);
    word = '0;
    for (int k = 0; k < 16 && k < invGot.size(); k++) word[127 - 8 * k -: 8] = invGot[k];
    checkEq("roundTrip", word, key);

    // Four back-to-back blocks, both ports always ready.
    $display("[TB] streaming");
    runCycles(2);
    fwdOutCount = 0; firstOutCyc = -1; lastOutCyc = -1;
    for (int i = 0; i < 64; i++) inQ.push_back(8'($urandom));
    startCyc = cyc;
    runCycles(82);
    checkEq("streamCount", 128'(fwdOutCount), 128'(64));
    checkEq("streamFirst", 128'(firstOutCyc - startCyc), 128'(16));
    checkEq("streamLast", 128'(lastOutCyc - startCyc), 128'(79));

    // Backpressure: two blocks fill, then stall until the first drains.
    $display("[TB] backpressure");
    outReady = 1'b0; acceptCount = 0;
    for (int i = 0; i < 48; i++) inQ.push_back(8'($urandom));
    runCycles(40);
    checkEq("bpAccepted", 128'(acceptCount), 128'(32));
    checkEq("bpInReadyLow", 128'(fwdInReady), 128'(0));
    checkEq("bpOutValid", 128'(fwdOutValid), 128'(1));
    outReady = 1'b1;
    runCycles(15);
    checkEq("bpStillBlocked", 128'(fwdInReady), 128'(0));
    runCycles(1);
    checkEq("bpReassert", 128'(fwdInReady), 128'(1));
    randOut = 1'b1;
    drainAll("bpDrain", 500);

    // Random handshakes on both sides over several blocks.
    $display("[TB] random handshakes");
    randIn = 1'b1; acceptCount = 0;
    for (int i = 0; i < 80; i++) inQ.push_back(8'($urandom));
    drainAll("randDrain", 2000);
    checkEq("randAccepted", 128'(acceptCount), 128'(80));
    randIn = 1'b0; randOut = 1'b0; outReady = 1'b1;

    // Reset in the middle of a block.
    $display("[TB] reset mid-block");
    acceptCount = 0;
    for (int i = 0; i < 16; i++) inQ.push_back(8'($urandom));
    budget = 50;
    while (acceptCount < 7 && budget > 0) begin
      runCycles(1);
      budget--;
    end
    checkEq("midAccepted", 128'(acceptCount), 128'(7));
    #2 rst = 1'b1;
    #1;
    checkResetOutputs("midReset");
    clearModel();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) inQ.push_back(8'($urandom));
    drainAll("midFreshDrain", 100);

    // Reset while a full block waits on a stalled consumer.
    $display("[TB] reset with pending block");
    outReady = 1'b0;
    for (int i = 0; i < 16; i++) inQ.push_back(8'($urandom));
    budget = 40;
    while (!fwdOutValid && budget > 0) begin
      runCycles(1);
      budget--;
    end
    checkEq("pendOutValid", 128'(fwdOutValid), 128'(1));
    #2 rst = 1'b1;
    #1;
    checkResetOutputs("pendReset");
    clearModel();
    @(posedge clk); #1;
    rst = 1'b0;
    outReady = 1'b1;
    runCycles(10);
    for (int i = 0; i < 16; i++) inQ.push_back(8'($urandom));
    drainAll("pendFreshDrain", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
